// File: rtl/johnson_decoder_pkg.sv
// rtl/johnson_decoder_pkg.sv - shared types, constants and helpers for the Johnson decoder
package johnson_decoder_pkg;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam int ERR_CNT_W = 8;

  // Index that must follow k in a 2*width-phase Johnson sequence
  function automatic int unsigned succ_idx(input int unsigned k, input int unsigned width);
    return (k + 1 >= 2 * width) ? 0 : k + 1;
  endfunction

endpackage

// File: rtl/johnson_decoder_if.sv
// rtl/johnson_decoder_if.sv - code sample input and decode/monitor outputs of the Johnson decoder
interface johnson_decoder_if
  import johnson_decoder_pkg::*;
#(
  parameter int WIDTH = 4
);
  localparam int IW = $clog2(2 * WIDTH);

  logic [WIDTH-1:0]     code;
  logic                 code_vld;
  logic [IW-1:0]        idx;
  logic [2*WIDTH-1:0]   onehot;
  logic                 legal;
  logic                 out_vld;
  logic                 locked;
  logic                 seq_err;
  logic [ERR_CNT_W-1:0] err_cnt;

  modport master (
    output code, code_vld,
    input  idx, onehot, legal, out_vld, locked, seq_err, err_cnt
  );

  modport slave (
    input  code, code_vld,
    output idx, onehot, legal, out_vld, locked, seq_err, err_cnt
  );

endinterface

// File: rtl/johnson_code_check.sv
// rtl/johnson_code_check.sv - combinational Johnson code to phase index and legality mapping
module johnson_code_check #(
  parameter int WIDTH = 4,
  parameter int IW    = $clog2(2 * WIDTH)
) (
  input  logic [WIDTH-1:0] code,
  output logic [IW-1:0]    idx,
  output logic             legal
);

  int               pop;
  logic [WIDTH-1:0] msb_pat;
  logic [WIDTH-1:0] lsb_pat;

  // LSB clear: ones packed against the MSB; LSB set: ones packed against the LSB
  always_comb begin
    pop     = 0;
    msb_pat = '0;
    lsb_pat = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pop = pop + int'(code[i]);
    end
    for (int i = 0; i < WIDTH; i++) begin
      msb_pat[i] = (i >= WIDTH - pop);
      lsb_pat[i] = (i < pop);
    end
    legal = code[0] ? (code == lsb_pat) : (code == msb_pat);
    idx   = '0;
    if (legal) begin
      idx = code[0] ? IW'(2 * WIDTH - pop) : IW'(pop);
    end
  end

endmodule

// File: rtl/johnson_decoder.sv
// rtl/johnson_decoder.sv - Johnson code decoder and sequence lock monitor (onehot built only with JOHNSON_DECODER_ONEHOT_EN)
module johnson_decoder
  import johnson_decoder_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int LOCK_CNT = 3
) (
  input  logic               clk,
  input  logic               rst,
  johnson_decoder_if.slave   bus
);

  localparam int IW = $clog2(2 * WIDTH);

  logic [IW-1:0]        ck_idx;
  logic                 ck_legal;
  logic                 step_ok;

  state_t               state_q, state_n;
  logic [3:0]           run_q, run_n;
  logic [IW-1:0]        prev_idx_q, prev_idx_n;
  logic                 prev_ok_q, prev_ok_n;
  logic [ERR_CNT_W-1:0] err_q, err_n;
  logic                 seq_err_q, seq_err_n;

  logic [IW-1:0]        idx_q;
  logic                 legal_q;
  logic                 out_vld_q;

  johnson_code_check #(
    .WIDTH (WIDTH),
    .IW    (IW)
  ) u_check (
    .code  (bus.code),
    .idx   (ck_idx),
    .legal (ck_legal)
  );

  assign step_ok = ck_legal && prev_ok_q &&
                   (32'(ck_idx) == succ_idx(32'(prev_idx_q), WIDTH));

  // Lock FSM next state, run length, last-good index and error accounting
  always_comb begin
    state_n    = state_q;
    run_n      = run_q;
    prev_idx_n = prev_idx_q;
    prev_ok_n  = prev_ok_q;
    err_n      = err_q;
    seq_err_n  = 1'b0;
    if (bus.code_vld) begin
      case (state_q)
        HUNT: begin
          if (ck_legal) begin
            prev_idx_n = ck_idx;
            prev_ok_n  = 1'b1;
            if (step_ok) begin
              if (run_q + 4'd1 == 4'(LOCK_CNT)) begin
                state_n = LOCKED;
                run_n   = 4'd0;
              end else begin
                run_n = run_q + 4'd1;
              end
            end else begin
              run_n = 4'd0;
            end
          end else begin
            run_n     = 4'd0;
            prev_ok_n = 1'b0;
          end
        end
        LOCKED: begin
          if (step_ok) begin
            prev_idx_n = ck_idx;
          end else begin
            seq_err_n = 1'b1;
            err_n     = (err_q == '1) ? err_q : err_q + 8'd1;
            state_n   = HUNT;
            run_n     = 4'd0;
            if (ck_legal) begin
              prev_idx_n = ck_idx;
              prev_ok_n  = 1'b1;
            end else begin
              prev_ok_n  = 1'b0;
            end
          end
        end
        default: state_n = HUNT;
      endcase
    end
  end

  // Lock FSM and monitor state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= HUNT;
      run_q      <= 4'd0;
      prev_idx_q <= '0;
      prev_ok_q  <= 1'b0;
      err_q      <= '0;
      seq_err_q  <= 1'b0;
    end else begin
      state_q    <= state_n;
      run_q      <= run_n;
      prev_idx_q <= prev_idx_n;
      prev_ok_q  <= prev_ok_n;
      err_q      <= err_n;
      seq_err_q  <= seq_err_n;
    end
  end

  // Decode result registers; hold their value while no sample arrives
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q     <= '0;
      legal_q   <= 1'b0;
      out_vld_q <= 1'b0;
    end else if (bus.code_vld) begin
      idx_q     <= ck_idx;
      legal_q   <= ck_legal;
      out_vld_q <= 1'b1;
    end else begin
      out_vld_q <= 1'b0;
    end
  end

`ifdef JOHNSON_DECODER_ONEHOT_EN
  logic [2*WIDTH-1:0] onehot_q;
  logic [2*WIDTH-1:0] onehot_n;

  // One-hot phase decode of the checker index
  always_comb begin
    onehot_n = '0;
    if (ck_legal) begin
      onehot_n[ck_idx] = 1'b1;
    end
  end

  // One-hot phase register, updated alongside idx
  always_ff @(posedge clk) begin
    if (rst) begin
      onehot_q <= '0;
    end else if (bus.code_vld) begin
      onehot_q <= onehot_n;
    end
  end

  assign bus.onehot = onehot_q;
`else
  assign bus.onehot = '0;
`endif

  assign bus.idx     = idx_q;
  assign bus.legal   = legal_q;
  assign bus.out_vld = out_vld_q;
  assign bus.locked  = (state_q == LOCKED);
  assign bus.seq_err = seq_err_q;
  assign bus.err_cnt = err_q;

endmodule

// File: tb/tb_johnson_decoder.sv
// tb/tb_johnson_decoder.sv - self-checking bench for johnson_decoder (honours JOHNSON_DECODER_ONEHOT_EN)
module tb_johnson_decoder;

  localparam int W  = 4;
  localparam int N  = 2 * W;
  localparam int LC = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int tests = 0;
  int fails = 0;

  johnson_decoder_if #(.WIDTH(W)) bus ();

  johnson_decoder #(
    .WIDTH    (W),
    .LOCK_CNT (LC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Johnson step table, built by running the counter rule
  logic [W-1:0] tbl [N];

  // Expected outputs and abstract monitor state
  logic [2:0] e_idx;
  logic [7:0] e_oh;
  logic       e_legal, e_ov, e_locked, e_serr;
  int         e_err;
  int         m_run, m_prev;
  bit         m_prev_ok;
  bit         started = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: decode by table lookup, lock/error rules applied per sample
  always @(posedge clk) begin
    int  k;
    bit  lg, good;
    started = 1;
    if (rst) begin
      e_idx = 0; e_oh = 0; e_legal = 0; e_ov = 0; e_locked = 0; e_serr = 0; e_err = 0;
      m_run = 0; m_prev = 0; m_prev_ok = 0;
    end else if (bus.code_vld) begin
      lg = 0; k = 0;
      for (int i = 0; i < N; i++) if (tbl[i] == bus.code) begin lg = 1; k = i; end
      e_idx   = lg ? 3'(k) : 3'd0;
`ifdef JOHNSON_DECODER_ONEHOT_EN
      e_oh    = lg ? 8'(1 << k) : 8'd0;
`else
      e_oh    = 8'd0;
`endif
      e_legal = lg;
      e_ov    = 1;
      e_serr  = 0;
      good    = lg && m_prev_ok && (k == (m_prev + 1) % N);
      if (!e_locked) begin
        if (lg) begin
          m_run     = good ? m_run + 1 : 0;
          m_prev    = k;
          m_prev_ok = 1;
          if (m_run >= LC) begin e_locked = 1; m_run = 0; end
        end else begin
          m_run = 0; m_prev_ok = 0;
        end
      end else if (good) begin
        m_prev = k;
      end else begin
        e_serr   = 1;
        e_err    = (e_err >= 255) ? 255 : e_err + 1;
        e_locked = 0;
        m_run    = 0;
        if (lg) begin m_prev = k; m_prev_ok = 1; end
        else m_prev_ok = 0;
      end
    end else begin
      e_ov   = 0;
      e_serr = 0;
    end
  end

  // Compare every output against the model on each falling edge
  always @(negedge clk) begin
    if (started) begin
      chk("idx",     bus.idx,     e_idx);
      chk("onehot",  bus.onehot,  e_oh);
      chk("legal",   bus.legal,   e_legal);
      chk("out_vld", bus.out_vld, e_ov);
      chk("locked",  bus.locked,  e_locked);
      chk("seq_err", bus.seq_err, e_serr);
      chk("err_cnt", bus.err_cnt, e_err);
    end
  end

  task automatic drive(input logic [W-1:0] c, input logic v);
    @(negedge clk);
    bus.code     = c;
    bus.code_vld = v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [W-1:0] c;
    int cur;
    c = '0;
    for (int i = 0; i < N; i++) begin
      tbl[i] = c;
      c = {~c[0], c[W-1:1]};
    end

    // Reset with a sample present: the sample must be discarded
    rst = 1'b1;
    bus.code = 4'b1000;
    bus.code_vld = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_vld", bus.out_vld, 0);
    chk("rst_idx",     bus.idx,     0);
    chk("rst_locked",  bus.locked,  0);
    chk("rst_err_cnt", bus.err_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    bus.code_vld = 1'b0;

    // Two full passes of the step order
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < N; k++) begin
        drive(tbl[k], 1'b1);
        chk("pass_idx", bus.idx, k);
        if (r == 0 && k == 0) begin
`ifdef JOHNSON_DECODER_ONEHOT_EN
          chk("onehot_idx0", bus.onehot, 8'b0000_0001);
`else
          chk("onehot_off", bus.onehot, 8'b0000_0000);
`endif
        end
        if (r == 0 && k == 2) chk("not_yet_locked", bus.locked, 0);
        if (r == 0 && k == 3) chk("locked_after_4", bus.locked, 1);
      end
    end

    // Illegal code while locked
    drive(4'b1010, 1'b1);
    chk("ill_legal",   bus.legal,   0);
    chk("ill_seq_err", bus.seq_err, 1);
    chk("ill_locked",  bus.locked,  0);
    chk("ill_err_cnt", bus.err_cnt, 1);
    drive(4'b0000, 1'b0);
    chk("ill_pulse_end", bus.seq_err, 0);

    // Relock, then skip idx 2 -> 4
    for (int k = 0; k < 4; k++) drive(tbl[k], 1'b1);
    chk("relock", bus.locked, 1);
    for (int k = 4; k < 11; k++) drive(tbl[k % N], 1'b1);
    drive(tbl[4], 1'b1);
    chk("skip_seq_err", bus.seq_err, 1);
    chk("skip_locked",  bus.locked,  0);
    chk("skip_err_cnt", bus.err_cnt, 2);
    chk("skip_idx",     bus.idx,     4);
    drive(tbl[5], 1'b1);
    drive(tbl[6], 1'b1);
    drive(tbl[7], 1'b1);
    chk("skip_then_lock", bus.locked, 1);

    // Gap in code_vld is not a break
    repeat (5) begin
      drive(4'b1010, 1'b0);
      chk("gap_out_vld", bus.out_vld, 0);
      chk("gap_locked",  bus.locked,  1);
    end
    drive(tbl[0], 1'b1);
    chk("gap_resume_locked", bus.locked,  1);
    chk("gap_resume_err",    bus.seq_err, 0);

    // Repeat errors until the counter saturates
    cur = 0;
    repeat (256) begin
      drive(tbl[cur], 1'b1);
      for (int j = 0; j < 3; j++) begin
        cur = (cur + 1) % N;
        drive(tbl[cur], 1'b1);
      end
    end
    chk("sat_err_cnt", bus.err_cnt, 255);
    chk("sat_locked",  bus.locked,  1);
    drive(tbl[cur], 1'b1);
    chk("sat_seq_err", bus.seq_err, 1);
    chk("sat_hold",    bus.err_cnt, 255);
    for (int j = 0; j < 3; j++) begin
      cur = (cur + 1) % N;
      drive(tbl[cur], 1'b1);
    end
    chk("sat_relock", bus.locked, 1);

    // Reset while locked with a valid sample present
    @(negedge clk);
    rst = 1'b1;
    bus.code = tbl[(cur + 1) % N];
    bus.code_vld = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_locked",  bus.locked,  0);
    chk("mid_rst_err_cnt", bus.err_cnt, 0);
    chk("mid_rst_out_vld", bus.out_vld, 0);
    chk("mid_rst_idx",     bus.idx,     0);
    chk("mid_rst_onehot",  bus.onehot,  0);
    @(negedge clk);
    rst = 1'b0;
    bus.code_vld = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/johnson_decoder.md
# johnson_decoder

Receive-side companion to the team's WIDTH-bit Johnson (twisted-ring) counter. It samples a Johnson code each valid cycle and decodes it to a binary phase index and a one-hot phase vector. It also checks that each code is legal and that consecutive codes follow the counter's step order. A lock state machine and a saturating error counter make it usable as a sequence monitor on any Johnson-coded bus in the design.

## Interface
Parameters:
- WIDTH, 4, Johnson code width; sequence length is 2*WIDTH phases.
- LOCK_CNT, 3, consecutive correct successor steps required to enter LOCKED (1..15).
- IW, $clog2(2*WIDTH), phase index width (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- code  input  WIDTH  Johnson code under test.
- code_vld  input  1  code is sampled this cycle.
- idx  output  IW  decoded phase index, 0..2*WIDTH-1.
- onehot  output  2*WIDTH  bit idx set when legal.
- legal  output  1  last sampled code was a legal Johnson code.
- out_vld  output  1  idx/onehot/legal updated this cycle.
- locked  output  1  state == LOCKED.
- seq_err  output  1  one-cycle pulse on a sequence or legality error while LOCKED.
- err_cnt  output  8  saturating count of seq_err pulses.

## Operation
- Step order (reset code 0, WIDTH=4): 0000, 1000, 1100, 1110, 1111, 0111, 0011, 0001, then wraps to 0000. The MSB fills first; the next-state function is code[i] <= code[i+1], code[W-1] <= ~code[0].
- Decode when code[0]==0: the ones must be contiguous from the MSB, and idx = popcount.
- Decode when code[0]==1: the ones must be contiguous from the LSB, and idx = 2*WIDTH - popcount.
- Any other pattern is illegal: legal=0, idx=0, onehot=0.
- The successor of idx k is (k+1) mod 2*WIDTH; wrap from 2*WIDTH-1 to 0 is a correct step.
- An internal prev_idx and prev_ok record the last legal sampled code.
- State HUNT (reset state), on a legal sample:
  - a correct successor of prev_idx increments run;
  - otherwise run = 0.
  - prev_idx is always updated.
- State HUNT, on an illegal sample: run = 0 and prev_ok = 0.
- State HUNT, exit: run reaching LOCK_CNT moves to LOCKED.
- State LOCKED, on a sample that is illegal, a repeat, or a skip:
  - seq_err pulses and err_cnt increments, saturating at 255;
  - the state moves to HUNT with run = 0;
  - prev_idx takes the new code if it is legal (prev_ok = 1), otherwise prev_ok = 0.
- code_vld low means no sample: outputs and state hold, out_vld = 0, and no error is raised. A gap in code_vld is not a sequence break.

## Timing
- All outputs are registered.
- A sample at edge N appears on idx, onehot, legal and out_vld after edge N, giving 1-cycle latency.
- seq_err and the locked transition are visible in the same cycle as the corresponding out_vld.
- Reset values: idx=0, onehot=0, legal=0, out_vld=0, locked=0, seq_err=0, err_cnt=0, state=HUNT, run=0, prev_ok=0.
- rst asserted together with code_vld: reset wins and the sample is discarded.
- Reset mid-lock: locked drops after the reset edge and err_cnt clears.
- err_cnt at 255 stays at 255; seq_err still pulses.

## Configuration
- JOHNSON_DECODER_ONEHOT_EN defined: the onehot register and its decode are built, and onehot behaves as above.
- JOHNSON_DECODER_ONEHOT_EN undefined: the onehot port remains, is tied to all-zero, and no onehot flops are built.
- All other outputs are identical in both builds.

## Structure
- Package johnson_decoder_pkg holds:
  - the state enum (HUNT, LOCKED);
  - the ERR_CNT_W=8 constant;
  - a function computing the successor index mod 2*WIDTH.
- One sub-module, johnson_code_check: purely combinational. It maps code to idx and legal, and is reusable by other Johnson-bus monitors.
- The top level holds the registers, the FSM, run, and err_cnt.

## Test plan
- Reset, then feed the 8 codes of the WIDTH=4 step order from 0000, twice.
  - idx follows 0..7,0..7 one cycle after each sample.
  - onehot=8'b0000_0001 for idx 0.
  - locked rises after the 4th sample (3 successor steps).
  - seq_err stays 0.
- While locked, inject 1010.
  - legal=0 and seq_err pulses once.
  - locked falls and err_cnt becomes 1.
- While locked, skip from 1100 straight to 1111 (idx 2 to idx 4).
  - seq_err pulses and locked falls.
  - prev_idx becomes 4, so 0111 then counts as a correct step.
- Deassert code_vld for 5 cycles mid-sequence, then resume with the correct successor.
  - out_vld stays 0 through the gap.
  - locked holds and there is no error.
- Force 256 lock/error cycles: err_cnt saturates at 255.
- Assert rst while LOCKED with code_vld=1: all outputs return to reset values on the next cycle.
- Repeat the first scenario with JOHNSON_DECODER_ONEHOT_EN undefined: onehot stays 0 and all other outputs are unchanged.
